// File: rtl/tmds_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Package     : tmds_pkg
// Description : Definitions shared by the TMDS encoder and decoder: the four
//               control-period tokens, the token-to-control-value mapping
//               and the decoder alignment state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tmds_pkg;

    // Control-period characters, named by the {c1,c0} value they carry.
    localparam logic [9:0] c_tok_00 = 10'h354;
    localparam logic [9:0] c_tok_01 = 10'h0AB;
    localparam logic [9:0] c_tok_10 = 10'h154;
    localparam logic [9:0] c_tok_11 = 10'h2AB;

    // Word-alignment state of the decoder.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } dec_state_t;

    // Returns {is_token, ctrl[1:0]}; ctrl is 2'b00 for non-token words.
    function automatic logic [2:0] f_token_to_ctrl(input logic [9:0] word);
        logic [2:0] res;
        case (word)
            c_tok_00: res = 3'b100;
            c_tok_01: res = 3'b101;
            c_tok_10: res = 3'b110;
            c_tok_11: res = 3'b111;
            default:  res = 3'b000;
        endcase
        return res;
    endfunction

endpackage : tmds_pkg
`default_nettype wire

// File: rtl/tmds_word_decode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tmds_word_decode
// Description : Purely combinational classification and decode of a single
//               10-bit TMDS character.
// Ports       : tmds    - 10-bit character, bit 0 first on the wire
//               is_ctrl - 1 when the character is one of the four tokens
//               ctrl    - control value carried by a token (0 otherwise)
//               data    - video byte recovered from the character
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] tmds,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [2:0] w_tok;
    logic [7:0] w_d;

    always_comb begin
        w_tok   = f_token_to_ctrl(tmds);
        is_ctrl = w_tok[2];
        ctrl    = w_tok[1:0];

        // Undo the optional inversion, then the XOR/XNOR chain selected by bit 8.
        w_d     = tmds[9] ? ~tmds[7:0] : tmds[7:0];
        data    = '0;
        data[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = tmds[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

endmodule : tmds_word_decode
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tmds_decoder
// Description : TMDS channel decoder. Registers the deserialized character,
//               hunts for a run of control tokens to acquire word alignment
//               (requesting single-bit slips when none is found), and once
//               locked outputs video data / control values two cycles after
//               the character is presented.
// Ports       : clk_in            - pixel clock, one character per cycle
//               rst_in            - asynchronous active-high reset
//               tmds_in           - parallel TMDS character
//               data_out          - decoded video byte
//               control_out       - decoded control value
//               ve_out            - 1 = video period, 0 = control period
//               locked_out        - word alignment acquired
//               bitslip_out       - one-cycle slip request to deserializer
//               disparity_err_out - sticky running-disparity violation
// Config      : DISPARITY_CHECK_EN - build the running-disparity monitor;
//               when undefined disparity_err_out is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN      = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int SLIP_WAIT     = 16,
    parameter int LOSS_TIMEOUT  = 8192
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       ve_out,
    output logic       locked_out,
    output logic       bitslip_out,
    output logic       disparity_err_out
);

    localparam int c_run_w  = $clog2(CTRL_RUN) + 1;
    localparam int c_word_w = $clog2(SEARCH_WINDOW) + 1;
    localparam int c_slip_w = $clog2(SLIP_WAIT) + 1;
    localparam int c_tout_w = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [c_run_w-1:0]  c_run_last  = c_run_w'(CTRL_RUN - 1);
    localparam logic [c_word_w-1:0] c_word_last = c_word_w'(SEARCH_WINDOW - 1);
    localparam logic [c_slip_w-1:0] c_slip_last = c_slip_w'(SLIP_WAIT - 1);
    localparam logic [c_tout_w-1:0] c_tout_last = c_tout_w'(LOSS_TIMEOUT - 1);

    logic [9:0]          r_tmds;
    dec_state_t          r_state;
    logic [c_word_w-1:0] r_word_cnt;
    logic [c_run_w-1:0]  r_run_cnt;
    logic [c_slip_w-1:0] r_slip_cnt;
    logic [c_tout_w-1:0] r_tout_cnt;

    logic       w_is_ctrl;
    logic [1:0] w_ctrl;
    logic [7:0] w_data;
    logic       w_lock_now;
    logic       w_loss_now;

    tmds_word_decode u_word_decode (
        .tmds    (r_tmds),
        .is_ctrl (w_is_ctrl),
        .ctrl    (w_ctrl),
        .data    (w_data)
    );

    // The token that completes the run is itself the first locked output.
    assign w_lock_now = (r_state == SEARCH) && w_is_ctrl && (r_run_cnt == c_run_last);
    // The video word that exhausts the timeout is dropped, not output.
    assign w_loss_now = (r_state == LOCKED) && !w_is_ctrl && (r_tout_cnt == c_tout_last);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tmds      <= '0;
            r_state     <= SEARCH;
            r_word_cnt  <= '0;
            r_run_cnt   <= '0;
            r_slip_cnt  <= '0;
            r_tout_cnt  <= '0;
            data_out    <= '0;
            control_out <= '0;
            ve_out      <= 1'b0;
            locked_out  <= 1'b0;
            bitslip_out <= 1'b0;
        end else begin
            r_tmds      <= tmds_in;
            bitslip_out <= 1'b0;
            case (r_state)
                SEARCH: begin
                    if (w_lock_now) begin
                        r_state     <= LOCKED;
                        r_word_cnt  <= '0;
                        r_run_cnt   <= '0;
                        r_tout_cnt  <= '0;
                        locked_out  <= 1'b1;
                        ve_out      <= 1'b0;
                        control_out <= w_ctrl;
                    end else if (r_word_cnt == c_word_last) begin
                        r_state     <= SLIP;
                        r_word_cnt  <= '0;
                        r_run_cnt   <= '0;
                        r_slip_cnt  <= '0;
                        bitslip_out <= 1'b1;
                    end else begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        r_run_cnt  <= w_is_ctrl ? r_run_cnt + 1'b1 : '0;
                    end
                end
                SLIP: begin
                    // Words arriving while the deserializer re-aligns are ignored.
                    if (r_slip_cnt == c_slip_last) begin
                        r_state    <= SEARCH;
                        r_slip_cnt <= '0;
                        r_word_cnt <= '0;
                        r_run_cnt  <= '0;
                    end else begin
                        r_slip_cnt <= r_slip_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_is_ctrl) begin
                        r_tout_cnt  <= '0;
                        ve_out      <= 1'b0;
                        control_out <= w_ctrl;
                    end else if (w_loss_now) begin
                        r_state     <= SEARCH;
                        r_tout_cnt  <= '0;
                        r_word_cnt  <= '0;
                        r_run_cnt   <= '0;
                        locked_out  <= 1'b0;
                        ve_out      <= 1'b0;
                        data_out    <= '0;
                        control_out <= '0;
                    end else begin
                        r_tout_cnt <= r_tout_cnt + 1'b1;
                        ve_out     <= 1'b1;
                        data_out   <= w_data;
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

`ifdef DISPARITY_CHECK_EN
    logic signed [6:0] r_disp_sum;
    logic        [3:0] w_ones;
    logic signed [7:0] w_disp_delta;
    logic signed [7:0] w_disp_raw;
    logic signed [7:0] w_disp_sat;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < 10; i++) begin
            w_ones = w_ones + 4'(r_tmds[i]);
        end
        // 2*ones - 10: excess of ones over zeros in this character.
        w_disp_delta = $signed({3'b000, w_ones, 1'b0}) - 8'sd10;
        w_disp_raw   = $signed({r_disp_sum[6], r_disp_sum}) + w_disp_delta;
        if (w_disp_raw > 8'sd63) begin
            w_disp_sat = 8'sd63;
        end else if (w_disp_raw < -8'sd63) begin
            w_disp_sat = -8'sd63;
        end else begin
            w_disp_sat = w_disp_raw;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_disp_sum        <= '0;
            disparity_err_out <= 1'b0;
        end else if (w_lock_now || w_loss_now) begin
            r_disp_sum        <= '0;
            disparity_err_out <= 1'b0;
        end else if ((r_state == LOCKED) && !w_is_ctrl) begin
            r_disp_sum <= w_disp_sat[6:0];
            if ((w_disp_sat > 8'sd20) || (w_disp_sat < -8'sd20)) begin
                disparity_err_out <= 1'b1;
            end
        end
    end
`else
    assign disparity_err_out = 1'b0;
`endif

endmodule : tmds_decoder
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tmds_decoder
// Description : Self-checking bench for tmds_decoder. Expected outputs are
//               queued as each character is driven and compared when the
//               character reaches the outputs two cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_decoder;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [9:0] tmds_in = 10'h100;
    logic [7:0] data_out;
    logic [1:0] control_out;
    logic       ve_out;
    logic       locked_out;
    logic       bitslip_out;
    logic       disparity_err_out;

    tmds_decoder dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .tmds_in           (tmds_in),
        .data_out          (data_out),
        .control_out       (control_out),
        .ve_out            (ve_out),
        .locked_out        (locked_out),
        .bitslip_out       (bitslip_out),
        .disparity_err_out (disparity_err_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // exp = {locked, ve, ctrl[1:0], data[7:0]}
    typedef struct {
        int          due;
        logic [11:0] exp;
        bit          ce;
        logic        err;
    } sb_t;

    sb_t        sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [1:0] m_ctrl = 2'b00;
    logic [7:0] m_data = 8'h00;
    logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return q;
    endfunction

    function automatic logic [2:0] ref_token(input logic [9:0] w);
        case (w)
            10'h354: return 3'b100;
            10'h0AB: return 3'b101;
            10'h154: return 3'b110;
            10'h2AB: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [9:0] rand_video();
        logic [9:0] w;
        logic [2:0] t;
        w = 10'($urandom_range(0, 1023));
        t = ref_token(w);
        while (t[2]) begin
            w = 10'($urandom_range(0, 1023));
            t = ref_token(w);
        end
        return w;
    endfunction

    // Drives one character; when use_model is set the expectation comes from
    // the locked-state model, otherwise from e.
    task automatic drive(input logic [9:0] w, input bit use_model, input logic [11:0] e,
                         input bit ce, input logic er);
        sb_t        s;
        logic [2:0] t;
        logic [11:0] x;
        x = e;
        if (use_model) begin
            t = ref_token(w);
            if (t[2]) m_ctrl = t[1:0];
            else      m_data = ref_decode(w);
            x = {1'b1, ~t[2], m_ctrl, m_data};
        end
        @(posedge clk_in);
        #1;
        tmds_in = w;
        s.due = cyc + 2;
        s.exp = x;
        s.ce  = ce;
        s.err = er;
        sb.push_back(s);
    endtask

    task automatic pulse_reset();
        tmds_in = 10'h100;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_in  = 1'b1;
        tmds_in = 10'h100;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        total += 6;
        if (data_out !== 8'h00)        begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
        if (control_out !== 2'b00)     begin bad++; $display("FAIL reset_ctrl got=%b want=00", control_out); end
        if (ve_out !== 1'b0)           begin bad++; $display("FAIL reset_ve got=%b want=0", ve_out); end
        if (locked_out !== 1'b0)       begin bad++; $display("FAIL reset_locked got=%b want=0", locked_out); end
        if (bitslip_out !== 1'b0)      begin bad++; $display("FAIL reset_bitslip got=%b want=0", bitslip_out); end
        if (disparity_err_out !== 1'b0) begin bad++; $display("FAIL reset_disp got=%b want=0", disparity_err_out); end
        rst_in = 1'b0;
        sb.delete();
    endtask

    task automatic test_lock();
        sb_t s;
        bit  saw_slip = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(10'h354, 1'b0, (k == 7) ? 12'h800 : 12'h000, 1'b0, 1'b0);
            else       @(posedge clk_in);
            @(negedge clk_in);
            if (bitslip_out !== 1'b0) saw_slip = 1'b1;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                s = sb.pop_front();
                total++;
                if ({locked_out, ve_out, control_out, data_out} !== s.exp || s.due != cyc) begin
                    bad++;
                    $display("FAIL lock_seq k=%0d cyc=%0d got=%h want=%h", k, cyc,
                             {locked_out, ve_out, control_out, data_out}, s.exp);
                end
            end
        end
        total++;
        if (saw_slip !== 1'b0) begin bad++; $display("FAIL lock_no_slip got=%b want=0", saw_slip); end
        m_ctrl = 2'b00;
        m_data = 8'h00;
    endtask

    task automatic test_video();
        sb_t        s;
        logic [9:0] w;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      drive(10'h100, 1'b1, 12'h0, 1'b0, 1'b0);
            else if (k == 1) drive(10'h200, 1'b1, 12'h0, 1'b0, 1'b0);
            else if (k < 8) begin
                w = rand_video();
                drive(w, 1'b1, 12'h0, 1'b0, 1'b0);
            end else @(posedge clk_in);
            @(negedge clk_in);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                s = sb.pop_front();
                total++;
                if ({locked_out, ve_out, control_out, data_out} !== s.exp || s.due != cyc) begin
                    bad++;
                    $display("FAIL video k=%0d cyc=%0d got=%h want=%h", k, cyc,
                             {locked_out, ve_out, control_out, data_out}, s.exp);
                end
            end
        end
    endtask

    task automatic test_ctrl();
        sb_t        s;
        logic [9:0] seq [3] = '{10'h2AB, 10'h154, 10'h0AB};
        // Put a distinctive video byte in place so the hold is visible.
        for (int k = 0; k < 6; k++) begin
            if (k == 0)     drive(10'h200, 1'b1, 12'h0, 1'b0, 1'b0);
            else if (k < 4) drive(seq[k-1], 1'b1, 12'h0, 1'b0, 1'b0);
            else            @(posedge clk_in);
            @(negedge clk_in);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                s = sb.pop_front();
                total++;
                if ({locked_out, ve_out, control_out, data_out} !== s.exp || s.due != cyc) begin
                    bad++;
                    $display("FAIL ctrl k=%0d cyc=%0d got=%h want=%h", k, cyc,
                             {locked_out, ve_out, control_out, data_out}, s.exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        sb_t        s;
        logic [9:0] w;
        for (int k = 0; k < 50; k++) begin
            if (k < 48) begin
                if ($urandom_range(0, 2) == 0) w = toks[$urandom_range(0, 3)];
                else                           w = rand_video();
                drive(w, 1'b1, 12'h0, 1'b0, 1'b0);
            end else @(posedge clk_in);
            @(negedge clk_in);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                s = sb.pop_front();
                total++;
                if ({locked_out, ve_out, control_out, data_out} !== s.exp || s.due != cyc) begin
                    bad++;
                    $display("FAIL b2b k=%0d cyc=%0d got=%h want=%h", k, cyc,
                             {locked_out, ve_out, control_out, data_out}, s.exp);
                end
            end
        end
    endtask

    task automatic test_loss();
        sb_t s;
        // token, 8191 video words kept, 8192nd drops lock, then 8 tokens relock
        for (int k = 0; k < 8204; k++) begin
            if (k == 0)          drive(10'h354, 1'b1, 12'h0, 1'b0, 1'b0);
            else if (k <= 8191)  drive(10'h200, 1'b1, 12'h0, 1'b0, 1'b0);
            else if (k == 8192)  drive(10'h200, 1'b0, 12'h000, 1'b0, 1'b0);
            else if (k <= 8200)  drive(10'h354, 1'b0, (k == 8200) ? 12'h800 : 12'h000, 1'b0, 1'b0);
            else                 @(posedge clk_in);
            @(negedge clk_in);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                s = sb.pop_front();
                total++;
                if ({locked_out, ve_out, control_out, data_out} !== s.exp || s.due != cyc) begin
                    bad++;
                    $display("FAIL loss k=%0d cyc=%0d got=%h want=%h", k, cyc,
                             {locked_out, ve_out, control_out, data_out}, s.exp);
                end
            end
        end
        m_ctrl = 2'b00;
        m_data = 8'h00;
    endtask

    task automatic test_disparity();
        sb_t  s;
        logic e3;
`ifdef DISPARITY_CHECK_EN
        e3 = 1'b1;
`else
        e3 = 1'b0;
`endif
        pulse_reset();
        for (int k = 0; k < 15; k++) begin
            if (k < 8)       drive(10'h354, 1'b0, (k == 7) ? 12'h800 : 12'h000, 1'b1, 1'b0);
            else if (k < 11) drive(10'h3FF, 1'b0, 12'hC00, 1'b1, (k == 10) ? e3 : 1'b0);
            else if (k < 13) drive(10'h354, 1'b0, 12'h800, 1'b1, e3);
            else             @(posedge clk_in);
            @(negedge clk_in);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                s = sb.pop_front();
                total++;
                if ({locked_out, ve_out, control_out, data_out} !== s.exp || s.due != cyc) begin
                    bad++;
                    $display("FAIL disp_out k=%0d cyc=%0d got=%h want=%h", k, cyc,
                             {locked_out, ve_out, control_out, data_out}, s.exp);
                end
                total++;
                if (disparity_err_out !== s.err) begin
                    bad++;
                    $display("FAIL disp_err k=%0d cyc=%0d got=%b want=%b", k, cyc, disparity_err_out, s.err);
                end
            end
        end
        pulse_reset();
        total++;
        if (disparity_err_out !== 1'b0) begin bad++; $display("FAIL disp_reset got=%b want=0", disparity_err_out); end
    endtask

    task automatic test_slip();
        int edges[$];
        int r;
        bit saw_lock = 1'b0;
        int want [3] = '{2048, 4112, 6176};
        tmds_in = 10'h100;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        r = cyc;
        for (int k = 0; k < 6200; k++) begin
            @(negedge clk_in);
            if (bitslip_out === 1'b1) edges.push_back(cyc - r);
            if (locked_out !== 1'b0) saw_lock = 1'b1;
        end
        total++;
        if (edges.size() != 3) begin
            bad++;
            $display("FAIL slip_count got=%0d want=3", edges.size());
        end
        for (int k = 0; k < 3; k++) begin
            if (k < edges.size()) begin
                total++;
                if (edges[k] != want[k]) begin
                    bad++;
                    $display("FAIL slip_time n=%0d got=%0d want=%0d", k, edges[k], want[k]);
                end
            end
        end
        total++;
        if (saw_lock !== 1'b0) begin bad++; $display("FAIL slip_no_lock got=%b want=0", saw_lock); end
    endtask

    task automatic test_async_reset();
        sb_t s;
        bit  seen = 1'b0;
        pulse_reset();
        m_ctrl = 2'b11;
        m_data = 8'h00;
        for (int k = 0; k < 13; k++) begin
            if (k < 8)       drive(10'h2AB, 1'b0, (k == 7) ? 12'hB00 : 12'h000, 1'b0, 1'b0);
            else if (k < 11) drive(10'h200, 1'b1, 12'h0, 1'b0, 1'b0);
            else             @(posedge clk_in);
            @(negedge clk_in);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                s = sb.pop_front();
                total++;
                if ({locked_out, ve_out, control_out, data_out} !== s.exp || s.due != cyc) begin
                    bad++;
                    $display("FAIL async_pre k=%0d cyc=%0d got=%h want=%h", k, cyc,
                             {locked_out, ve_out, control_out, data_out}, s.exp);
                end
            end
        end
        // Reset lands mid-cycle; outputs must clear before the next edge.
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        total++;
        if ({locked_out, ve_out, control_out, data_out, disparity_err_out} !== 13'h0) begin
            bad++;
            $display("FAIL async_clear got=%h want=0", {locked_out, ve_out, control_out, data_out, disparity_err_out});
        end
        // A slip pulse must be cut short by reset.
        tmds_in = 10'h100;
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int k = 0; k < 2200 && !seen; k++) begin
            @(negedge clk_in);
            if (bitslip_out === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL async_slip_wait got=timeout want=pulse");
        end else begin
            rst_in = 1'b1;
            #1;
            total++;
            if (bitslip_out !== 1'b0) begin bad++; $display("FAIL async_slip_cut got=%b want=0", bitslip_out); end
            @(negedge clk_in);
            rst_in = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_video();
        test_ctrl();
        test_back_to_back();
        test_loss();
        test_disparity();
        test_slip();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tmds_decoder
`default_nettype wire
